fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with a one-entry holding buffer and IF/ID register.
//
// A word returned by instruction memory while decode is stalled is parked in
// the holding buffer, so it is never lost or fetched twice.
//
// Parameter
//   NOP_INST   : word placed in ifid_inst whenever ifid_valid is 0
// Inputs
//   clk        : clock, all state updates on posedge
//   clrn       : synchronous active-low reset
//   pc         : current PC from the PC register
//   imem_rdata : instruction word, valid when imem_ready=1
//   imem_ready : memory returned imem_rdata for imem_addr this cycle
//   id_stall   : decode cannot accept a new instruction
//   flush      : branch/jump taken, discard fetched and held instruction
// Outputs
//   imem_req   : fetch request (combinational)
//   imem_addr  : fetch address, equal to pc (combinational)
//   pc_stall   : PC register hold request (combinational)
//   ifid_valid : IF/ID holds a real instruction
//   ifid_inst  : IF/ID instruction word
//   ifid_pc    : PC of ifid_inst
//   ifid_pc4   : ifid_pc + 4, modulo 2^32
//   fetch_cnt  : instructions delivered to IF/ID, wraps at 2^32
module fetch_stage #(
   parameter logic [31:0] NOP_INST = 32'h00000000
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic [31:0] pc,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        id_stall,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic        pc_stall,
   output logic        ifid_valid,
   output logic [31:0] ifid_inst,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc4,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [0:0] {StFetch, StHold} state_e;

   state_e      state_q;
   logic [31:0] hold_inst_q;
   logic [31:0] hold_pc_q;
   logic        valid_q;
   logic [31:0] inst_q;
   logic [31:0] pc_q;
   logic [31:0] pc4_q;
   logic [31:0] cnt_q;

   assign imem_addr  = pc;
   assign ifid_valid = valid_q;
   assign ifid_inst  = inst_q;
   assign ifid_pc    = pc_q;
   assign ifid_pc4   = pc4_q;
   assign fetch_cnt  = cnt_q;

   always_comb begin
      imem_req = 1'b0;
      pc_stall = 1'b0;
      if (clrn) begin
         imem_req = (state_q == StFetch);
         // A flush must let the PC load its redirect target.
         if (!flush) begin
            if (state_q == StFetch) pc_stall = ~imem_ready | id_stall;
            else                    pc_stall = id_stall;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state_q     <= StFetch;
         hold_inst_q <= 32'h0;
         hold_pc_q   <= 32'h0;
         valid_q     <= 1'b0;
         inst_q      <= NOP_INST;
         pc_q        <= 32'h0;
         pc4_q       <= 32'h0;
         cnt_q       <= 32'h0;
      end else if (flush) begin
         state_q     <= StFetch;
         hold_inst_q <= 32'h0;
         hold_pc_q   <= 32'h0;
         valid_q     <= 1'b0;
         inst_q      <= NOP_INST;
      end else begin
         unique case (state_q)
            StFetch: begin
               if (imem_ready && !id_stall) begin
                  valid_q <= 1'b1;
                  inst_q  <= imem_rdata;
                  pc_q    <= pc;
                  pc4_q   <= pc + 32'd4;
                  cnt_q   <= cnt_q + 32'd1;
               end else if (imem_ready) begin
                  hold_inst_q <= imem_rdata;
                  hold_pc_q   <= pc;
                  state_q     <= StHold;
               end else if (!id_stall) begin
                  // Bubble; ifid_pc/ifid_pc4 keep their last values.
                  valid_q <= 1'b0;
                  inst_q  <= NOP_INST;
               end
            end
            StHold: begin
               if (!id_stall) begin
                  valid_q <= 1'b1;
                  inst_q  <= hold_inst_q;
                  pc_q    <= hold_pc_q;
                  pc4_q   <= hold_pc_q + 32'd4;
                  cnt_q   <= cnt_q + 32'd1;
                  state_q <= StFetch;
               end
            end
            default: state_q <= StFetch;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a behavioural reference model.
module tb_fetch_stage;

   localparam logic [31:0] Nop = 32'h00000013;

   logic        clk;
   logic        clrn;
   logic [31:0] pc;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        id_stall;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        pc_stall;
   logic        ifid_valid;
   logic [31:0] ifid_inst;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;
   logic [31:0] fetch_cnt;

   int n_pass;
   int n_total;
   bit chk_en;

   fetch_stage #(.NOP_INST(Nop)) dut (
      .clk        (clk),
      .clrn       (clrn),
      .pc         (pc),
      .imem_rdata (imem_rdata),
      .imem_ready (imem_ready),
      .id_stall   (id_stall),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .pc_stall   (pc_stall),
      .ifid_valid (ifid_valid),
      .ifid_inst  (ifid_inst),
      .ifid_pc    (ifid_pc),
      .ifid_pc4   (ifid_pc4),
      .fetch_cnt  (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: what IF/ID shows, plus an optional parked instruction
   // that was returned while decode was stalled.
   bit          m_valid;
   logic [31:0] m_inst, m_pc, m_pc4, m_cnt;
   bit          m_parked;
   logic [31:0] m_park_inst, m_park_pc;

   task automatic deliver(input logic [31:0] inst, input logic [31:0] ipc);
      m_valid = 1'b1;
      m_inst  = inst;
      m_pc    = ipc;
      m_pc4   = ipc + 32'd4;
      m_cnt   = m_cnt + 32'd1;
   endtask

   always @(posedge clk) begin
      if (!clrn) begin
         m_valid = 0; m_inst = Nop; m_pc = 0; m_pc4 = 0; m_cnt = 0; m_parked = 0;
      end else if (flush) begin
         m_valid = 0; m_inst = Nop; m_parked = 0;
      end else if (m_parked) begin
         if (!id_stall) begin
            deliver(m_park_inst, m_park_pc);
            m_parked = 0;
         end
      end else if (imem_ready) begin
         if (id_stall) begin
            m_parked = 1; m_park_inst = imem_rdata; m_park_pc = pc;
         end else begin
            deliver(imem_rdata, pc);
         end
      end else if (!id_stall) begin
         m_valid = 0; m_inst = Nop;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         logic e_req, e_stall;
         e_req   = clrn && !m_parked;
         e_stall = clrn && !flush && (m_parked ? id_stall : (!imem_ready || id_stall));
         check("imem_req",   {31'b0, imem_req},   {31'b0, e_req});
         check("imem_addr",  imem_addr,            pc);
         check("pc_stall",   {31'b0, pc_stall},   {31'b0, e_stall});
         check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
         check("ifid_inst",  ifid_inst,            m_inst);
         check("ifid_pc",    ifid_pc,              m_pc);
         check("ifid_pc4",   ifid_pc4,             m_pc4);
         check("fetch_cnt",  fetch_cnt,            m_cnt);
      end
   end

   // Apply inputs for one cycle; returns 1 time unit after the capturing edge.
   task automatic cyc(input logic r, input logic [31:0] p, input logic [31:0] d,
                      input logic rdy, input logic st, input logic fl);
      clrn = r; pc = p; imem_rdata = d; imem_ready = rdy; id_stall = st; flush = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_pass = 0; n_total = 0; chk_en = 0;
      clrn = 0; pc = 0; imem_rdata = 0; imem_ready = 0; id_stall = 0; flush = 0;

      // Reset, with other inputs asserted to show reset wins.
      cyc(0, 32'h0, 32'hDEADBEEF, 1, 1, 1);
      chk_en = 1;
      cyc(0, 32'h0, 32'hDEADBEEF, 1, 0, 0);
      check("rst_valid", {31'b0, ifid_valid}, 32'd0);
      check("rst_inst",  ifid_inst, Nop);
      check("rst_cnt",   fetch_cnt, 32'd0);
      check("rst_req",   {31'b0, imem_req}, 32'd0);
      check("rst_stall", {31'b0, pc_stall}, 32'd0);

      // Streaming.
      cyc(1, 32'h100, 32'h11111111, 1, 0, 0);
      check("str_pc0",  ifid_pc,  32'h100);
      check("str_pc4",  ifid_pc4, 32'h104);
      check("str_stl",  {31'b0, pc_stall}, 32'd0);
      cyc(1, 32'h104, 32'h22222222, 1, 0, 0);
      check("str_pc1",  ifid_pc,   32'h104);
      check("str_cnt",  fetch_cnt, 32'd2);

      // Memory wait.
      cyc(1, 32'h200, 32'h0, 0, 0, 0);
      check("mw_valid0", {31'b0, ifid_valid}, 32'd0);
      check("mw_stall0", {31'b0, pc_stall}, 32'd1);
      cyc(1, 32'h200, 32'h0, 0, 0, 0);
      check("mw_valid1", {31'b0, ifid_valid}, 32'd0);
      check("mw_pcret",  ifid_pc, 32'h104);
      cyc(1, 32'h200, 32'h33333333, 1, 0, 0);
      check("mw_pc", ifid_pc, 32'h200);

      // Stall capture.
      cyc(1, 32'h300, 32'hAABBCCDD, 1, 1, 0);
      check("sc_req",   {31'b0, imem_req}, 32'd0);
      check("sc_stall", {31'b0, pc_stall}, 32'd1);
      check("sc_keep",  ifid_pc, 32'h200);
      cyc(1, 32'h300, 32'h0, 0, 1, 0);
      cyc(1, 32'h300, 32'h0, 0, 1, 0);
      check("sc_keep2", ifid_inst, 32'h33333333);
      cyc(1, 32'h300, 32'h0, 0, 0, 0);
      check("sc_inst", ifid_inst, 32'hAABBCCDD);
      check("sc_pc",   ifid_pc,   32'h300);
      check("sc_cnt",  fetch_cnt, 32'd4);
      cyc(1, 32'h304, 32'h44444444, 1, 0, 0);
      check("sc_next", ifid_pc,   32'h304);
      check("sc_cnt5", fetch_cnt, 32'd5);

      // FETCH, not ready, stalled: IF/ID holds.
      cyc(1, 32'h308, 32'h0, 0, 1, 0);
      check("fs_hold", ifid_inst, 32'h44444444);

      // Reset mid-HOLD.
      cyc(1, 32'h308, 32'h55555555, 1, 1, 0);
      check("rh_cnt5", fetch_cnt, 32'd5);
      cyc(0, 32'h308, 32'h0, 1, 1, 1);
      check("rh_pc",   ifid_pc,   32'd0);
      check("rh_pc4",  ifid_pc4,  32'd0);
      check("rh_cnt",  fetch_cnt, 32'd0);
      check("rh_inst", ifid_inst, Nop);
      check("rh_req",  {31'b0, imem_req}, 32'd0);
      cyc(1, 32'h500, 32'h77777777, 1, 0, 0);
      check("rh_after", ifid_inst, 32'h77777777);
      check("rh_cnt1",  fetch_cnt, 32'd1);

      // Flush in HOLD with id_stall held.
      cyc(1, 32'h504, 32'h55555555, 1, 1, 0);
      cyc(1, 32'h504, 32'h0, 0, 1, 1);
      check("fl_valid", {31'b0, ifid_valid}, 32'd0);
      check("fl_inst",  ifid_inst, Nop);
      check("fl_cnt",   fetch_cnt, 32'd1);
      cyc(1, 32'h600, 32'h66666666, 1, 0, 0);
      check("fl_next",  ifid_inst, 32'h66666666);
      check("fl_cnt2",  fetch_cnt, 32'd2);

      // Flush in FETCH with a ready word.
      cyc(1, 32'h604, 32'h88888888, 1, 0, 1);
      check("ff_valid", {31'b0, ifid_valid}, 32'd0);
      check("ff_cnt",   fetch_cnt, 32'd2);

      // PC wrap.
      cyc(1, 32'hFFFFFFFC, 32'h99999999, 1, 0, 0);
      check("wr_pc4", ifid_pc4, 32'h00000000);
      check("wr_cnt", fetch_cnt, 32'd3);
      cyc(1, 32'h0, 32'h0, 0, 0, 0);

      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
